// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, sizes and the board legend map for the keypad scanner.
// The legend map is applied only when KEYPAD_HEX_MAP_EN is defined (see keypad_scanner).
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Debounce FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Classification of one full four-row scan.
  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  // Raw index (row*4 + col) to the face legend printed on the board keypad.
  // Row 3 is "* 0 # D", with * shown as E and # as F.
  localparam logic [3:0] LEGEND_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Number of active-low (pressed) columns in one row sample.
  function automatic logic [2:0] count_low(input logic [3:0] c);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_COLS; i++) n = n + {2'b00, ~c[i]};
    return n;
  endfunction

  // Position of the lowest active-low column; only meaningful when one is low.
  function automatic logic [1:0] low_index(input logic [3:0] c);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) if (!c[i]) idx = 2'(i);
    return idx;
  endfunction

  // Raw key index to reported code; identity unless the legend map is enabled.
  function automatic logic [3:0] map_key(input logic [3:0] raw, input logic hex_en);
    return hex_en ? LEGEND_MAP[raw] : raw;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix pins plus the key event outputs.
interface keypad_scanner_if;
  // Event protocol: key_valid is a one-cycle pulse with no ready/backpressure;
  // key_code is valid in the pulse cycle and held stable until the next pulse;
  // key_held is a level from the pulse until the release is accepted.
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // master: the scanner (drives rows and key events, reads columns).
  modport master (
    output row, key_code, key_valid, key_held,
    input  col
  );

  // slave: the keypad/consumer side.
  modport slave (
    input  row, key_code, key_valid, key_held,
    output col
  );
endinterface

// File: rtl/keypad_row_scanner.sv
// keypad_row_scanner: column synchronizer, row slot sequencer and per-scan
// classifier. scan_done/scan_kind/scan_key are valid in the cycle of the
// row-3 sample so the debounce FSM registers its result on that same edge.
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       scan_done,
  output scan_kind_e scan_kind,
  output logic [3:0] scan_key
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [3:0]    col_s1_q, col_s2_q;
  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;   // keys seen so far this scan, saturating at 2
  logic [3:0]    acc_key_q, acc_key_d;   // raw index of the first key seen this scan
  logic          sample;
  logic [2:0]    tot;
  logic [3:0]    key_here;
  logic [3:0]    merged_key;

  // Two-flop synchronizer for the asynchronous column inputs (idle = all high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1_q <= 4'b1111;
      col_s2_q <= 4'b1111;
    end else begin
      col_s1_q <= col;
      col_s2_q <= col_s1_q;
    end
  end

  // Combine the current row sample with what earlier rows of this scan saw.
  always_comb begin
    sample     = (slot_cnt_q == DIV_LAST);
    tot        = {1'b0, acc_cnt_q} + count_low(col_s2_q);
    key_here   = {row_idx_q, low_index(col_s2_q)};
    merged_key = (acc_cnt_q == 2'd0) ? key_here : acc_key_q;
    row        = ~(4'b0001 << row_idx_q);
    scan_done  = sample && (row_idx_q == 2'd3);
    scan_key   = merged_key;
    if (tot == 3'd0)      scan_kind = SCAN_NONE;
    else if (tot == 3'd1) scan_kind = SCAN_SINGLE;
    else                  scan_kind = SCAN_MULTI;
  end

  // Slot counter, row advance after each sample, scan accumulator update.
  always_comb begin
    slot_cnt_d = slot_cnt_q + 1'b1;
    row_idx_d  = row_idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_key_d  = acc_key_q;
    if (sample) begin
      slot_cnt_d = '0;
      row_idx_d  = row_idx_q + 2'd1;
      if (row_idx_q == 2'd3) begin
        acc_cnt_d = '0;
        acc_key_d = '0;
      end else begin
        acc_cnt_d = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        acc_key_d = merged_key;
      end
    end
  end

  // Sequencer and accumulator registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt_q <= '0;
      row_idx_q  <= '0;
      acc_cnt_q  <= '0;
      acc_key_q  <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      row_idx_q  <= row_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_key_q  <= acc_key_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad scanner with scan-level debounce, one key code
// per press. Define KEYPAD_HEX_MAP_EN to report board legends instead of raw
// row*4+col indices.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 200000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp,
  output state_e            state_dbg
);

`ifdef KEYPAD_HEX_MAP_EN
  localparam logic HEX_MAP_EN = 1'b1;
`else
  localparam logic HEX_MAP_EN = 1'b0;
`endif

  localparam logic [4:0] DEB = 5'(DEBOUNCE_SCANS);

  logic       scan_done;
  scan_kind_e scan_kind;
  logic [3:0] scan_key;

  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
  logic       accept;
  logic [4:0] cnt_inc;

  keypad_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .col       (kp.col),
    .row       (kp.row),
    .scan_done (scan_done),
    .scan_kind (scan_kind),
    .scan_key  (scan_key)
  );

  // Debounce FSM: acts only on scan-complete events; accept overrides the
  // per-state next values so every accept path loads the outputs the same way.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    cnt_inc     = {1'b0, cnt_q} + 5'd1;
    if (scan_done) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_kind == SCAN_SINGLE) begin
            cand_d = scan_key;
            cnt_d  = 4'd1;
            if (DEB == 5'd1) accept = 1'b1;
            else             state_d = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (scan_kind == SCAN_SINGLE) begin
            if (scan_key == cand_q) begin
              cnt_d = cnt_inc[3:0];
              if (cnt_inc >= DEB) accept = 1'b1;
            end else begin
              cand_d = scan_key;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (scan_kind == SCAN_NONE) begin
            if (DEB == 5'd1) begin
              key_held_d = 1'b0;
              state_d    = ST_IDLE;
              cnt_d      = '0;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_RELEASE: begin
          if (scan_kind == SCAN_NONE) begin
            cnt_d = cnt_inc[3:0];
            if (cnt_inc >= DEB) begin
              key_held_d = 1'b0;
              state_d    = ST_IDLE;
              cnt_d      = '0;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (accept) begin
        key_code_d  = map_key(cand_d, HEX_MAP_EN);
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
        state_d     = ST_HELD;
        cnt_d       = '0;
      end
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad on the board, debounces it and delivers one key code per press. It sits on the input side of the quiz-game datapath, feeding contestant and host key presses to the control logic. It is the reading counterpart of the multiplexed seven-segment display driver: that block sweeps digit enables out, while this one sweeps row drives out and reads columns back.

## Interface
- SCAN_DIV, 200000: clk cycles per row slot; must be ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; must be ≥ 1, maximum 15.
- clk  input  1  system clock (100 MHz on the board).
- rst  input  1  asynchronous, active-low reset.
- row  output  4  row drive, active-low, one-hot-low.
- col  input  4  column sense, active-low, with external pull-ups; asynchronous.
- key_code  output  4  code of the last accepted key; held until the next accept.
- key_valid  output  1  one-clk pulse when a new key is accepted.
- key_held  output  1  high from accept until the release is accepted.

## Operation
- col passes through a 2-FF synchronizer before use.
- Row sequencer:
  - A counter runs 0..SCAN_DIV-1 and the row index runs 0..3, then wraps to 0.
  - row = ~(1 << row_idx).
  - Columns are sampled when the counter equals SCAN_DIV-1, then the row advances on the next clk.
- One full scan is 4 row slots. After the row-3 sample, the scan result is classified:
  - NONE: no column low in any row.
  - SINGLE(k): exactly one key down, with raw k = row_idx*4 + col_idx (col_idx = bit position of the low column).
  - MULTI: two or more keys down, including ghost patterns.
- FSM states:
  - IDLE: wait for a SINGLE scan.
  - CONFIRM: count matching scans against a candidate key.
  - HELD: key accepted and down.
  - RELEASE: count NONE scans until the release is accepted.
- FSM transitions, evaluated only at a scan-complete event:
  - IDLE: SINGLE(k) latches cand=k, sets cnt=1, goes to CONFIRM; if DEBOUNCE_SCANS=1, accepts immediately instead. NONE or MULTI stays in IDLE.
  - CONFIRM: SINGLE(cand) increments cnt; when cnt reaches DEBOUNCE_SCANS it accepts. SINGLE(other) reloads cand=other, cnt=1. NONE or MULTI returns to IDLE.
  - Accept: key_code <= map(cand), key_valid pulse, key_held <= 1, go to HELD.
  - HELD: NONE goes to RELEASE with cnt=1; if DEBOUNCE_SCANS=1, goes straight to IDLE with key_held <= 0. SINGLE or MULTI stays in HELD. A roll-over to another key is not a new press.
  - RELEASE: NONE increments cnt; at DEBOUNCE_SCANS the release is accepted: key_held <= 0, go to IDLE. Any key down returns to HELD.
- Only one key is accepted per press. A new press requires the release to be accepted first.

## Timing
- Reset values: row=4'b1110, key_code=0, key_valid=0, key_held=0, FSM in IDLE, counters at 0, synchronizer flops at 4'b1111.
- Reset is asynchronous assert and synchronous-safe deassert. Reset mid-press returns to IDLE; a key still held after reset is re-accepted after DEBOUNCE_SCANS scans.
- Column settle time before sampling is SCAN_DIV-1 cycles.
- key_valid is asserted in the clk cycle after the sampling edge of the accepting scan and lasts exactly one cycle.
- Press-to-valid latency, for a press stable before a scan start: DEBOUNCE_SCANS*4*SCAN_DIV + 3 cycles max (includes the 2 synchronizer cycles).
- A press that begins mid-scan adds up to one extra scan.
- key_held falls one cycle after the sampling edge of the DEBOUNCE_SCANS-th NONE scan.
- Row 3 wraps to row 0 without a gap; scan slots are continuous even while a key is held.

## Configuration
- KEYPAD_HEX_MAP_EN defined: map() converts the raw index to the face legend of the board keypad:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E(*) 0 F(#) D
- KEYPAD_HEX_MAP_EN undefined: map() is identity, so key_code = raw row*4 + col.

## Structure
- Package keypad_pkg holds:
  - FSM state encoding (IDLE=0, CONFIRM=1, HELD=2, RELEASE=3).
  - NUM_ROWS=4, NUM_COLS=4.
  - The 16-entry legend map constant.
- Sub-module keypad_row_scanner holds the synchronizer, slot counter, row driver and per-scan classifier. It outputs scan_done (1 cycle), scan_kind (NONE/SINGLE/MULTI) and scan_key[3:0].
- The top holds the debounce FSM and the output registers.

## Test plan
Bench runs with SCAN_DIV=4, DEBOUNCE_SCANS=2.
- Reset then idle: row cycles 1110,1101,1011,0111 every 4 clk; key_valid never pulses; key_held=0.
- Hold row1/col2 for 5 scans: exactly one key_valid pulse ≤ 35 clk after press; key_code=6 raw (0x6 mapped); key_held=1 until 2 NONE scans after release.
- Bounce (key down 1 scan, up 1 scan, repeated 4 times): no key_valid.
- Hold row0/col0 and row2/col1 together from idle: MULTI, so no key_valid. Press row0/col0 alone first, then add row2/col1 while held: one pulse with code 0, key_held stays 1.
- Release for 1 scan, then re-press the same key: no second pulse. Release for 2 scans, then re-press: second pulse.
- Assert rst mid-CONFIRM and mid-HELD: outputs return to reset values immediately; a key held through reset yields key_valid after 2 scans.
